// File: rtl/spi_device_lite.sv
// SPI mode-0 target with TL-UL register access and RX/TX byte FIFOs.
// SPI pins are oversampled in clk_i; all frame logic runs from synchronised edges.

package tlul_pkg;
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module spi_device_lite_fifo #(
    parameter int Depth = 8,
    localparam int AW = $clog2(Depth),
    localparam int LW = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [7:0]    wdata_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [7:0]    rdata_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [LW-1:0] level_o,
    output logic          drop_o
);
    localparam logic [LW-1:0] FullLvl = LW'(Depth);

    logic [7:0]    mem_q [Depth];
    logic [LW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic          do_pop, do_push;

    assign level_o = wptr_q - rptr_q;
    assign empty_o = (level_o == '0);
    assign full_o  = (level_o == FullLvl);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // A push into a full FIFO still succeeds when a pop frees a slot in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & ~flush_i & ~do_push;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
endmodule

module spi_device_lite #(
    parameter int         FifoDepth = 8,
    parameter logic [7:0] IdleByte  = 8'hFF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  tlul_pkg::tl_h2d_t  tl_i,
    output tlul_pkg::tl_d2h_t  tl_o,
    input  logic               sclk_i,
    input  logic               ss_ni,
    input  logic               sd_i,
    output logic               sd_o,
    output logic               sd_oe_o,
    output logic               intr_rx_o,
    output logic               intr_tx_o
);
    import tlul_pkg::*;

    localparam int LW = $clog2(FifoDepth) + 1;

    typedef enum logic {StIdle, StActive} state_e;

    function automatic logic [3:0] sat4(input logic [LW-1:0] lvl);
        logic [4:0] l5;
        l5 = 5'(lvl);
        return l5[4] ? 4'hF : l5[3:0];
    endfunction

    state_e      state_q, state_d;
    logic [2:0]  sclk_sync_q, sclk_sync_d, ss_sync_q, ss_sync_d;
    logic [1:0]  sd_sync_q, sd_sync_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        got_byte_q, got_byte_d;
    logic        sd_o_q, sd_o_d, sd_oe_q, sd_oe_d;
    logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic        rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
    logic        rx_ovf_q, rx_ovf_d, tx_unf_q, tx_unf_d, tx_ovf_q, tx_ovf_d;
    logic        d_valid_q, d_valid_d, d_error_q, d_error_d;
    logic [2:0]  d_opcode_q, d_opcode_d;
    logic [1:0]  d_size_q, d_size_d;
    logic [7:0]  d_source_q, d_source_d;
    logic [31:0] d_data_q, d_data_d;

    logic        sclk_rise, sclk_fall, ss_fall, ss_rise, sd_s;
    logic        spi_tx_pop, spi_rx_push, tx_unf_set;
    logic [7:0]  tx_next;
    logic        accept, is_get, is_put, bus_err, bus_wr, bus_rd;
    logic [1:0]  reg_idx;
    logic        bus_rx_pop, bus_tx_push, ctrl_wr, clr_sticky, rx_flush, tx_flush;
    logic [31:0] rdata, status;

    logic [7:0]    rx_head, tx_head;
    logic          rx_empty, rx_full, tx_empty, tx_full, rx_drop, tx_drop;
    logic [LW-1:0] rx_level, tx_level;
    logic          unused_tl;

    assign unused_tl = ^{tl_i.a_param, tl_i.a_mask, tl_i.a_address[1:0], tl_i.a_data[31:11]};

    spi_device_lite_fifo #(.Depth(FifoDepth)) u_rx_fifo (
        .clk_i, .rst_ni,
        .push_i(spi_rx_push), .wdata_i(rx_shift_d), .pop_i(bus_rx_pop), .flush_i(rx_flush),
        .rdata_o(rx_head), .empty_o(rx_empty), .full_o(rx_full), .level_o(rx_level),
        .drop_o(rx_drop)
    );

    spi_device_lite_fifo #(.Depth(FifoDepth)) u_tx_fifo (
        .clk_i, .rst_ni,
        .push_i(bus_tx_push), .wdata_i(tl_i.a_data[7:0]), .pop_i(spi_tx_pop), .flush_i(tx_flush),
        .rdata_o(tx_head), .empty_o(tx_empty), .full_o(tx_full), .level_o(tx_level),
        .drop_o(tx_drop)
    );

    // Stage 2 of each chain is the synchronised pin; stage 3 is the edge reference.
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
    assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
    assign sd_s      = sd_sync_q[1];
    assign tx_next   = tx_empty ? IdleByte : tx_head;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], sclk_i};
        ss_sync_d   = {ss_sync_q[1:0], ss_ni};
        sd_sync_d   = {sd_sync_q[0], sd_i};
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        got_byte_d  = got_byte_q;
        sd_o_d      = sd_o_q;
        sd_oe_d     = sd_oe_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        spi_tx_pop  = 1'b0;
        spi_rx_push = 1'b0;
        tx_unf_set  = 1'b0;
        case (state_q)
            StIdle: begin
                if (ss_fall) begin
                    state_d    = StActive;
                    bit_cnt_d  = 3'd0;
                    got_byte_d = 1'b0;
                    tx_shift_d = tx_next;
                    spi_tx_pop = ~tx_empty;
                    tx_unf_set = tx_empty;
                    sd_o_d     = tx_next[7];
                    sd_oe_d    = 1'b1;
                end
            end
            StActive: begin
                // Deselect wins over any clock edge seen in the same cycle.
                if (ss_rise) begin
                    state_d    = StIdle;
                    bit_cnt_d  = 3'd0;
                    got_byte_d = 1'b0;
                    sd_o_d     = 1'b1;
                    sd_oe_d    = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[6:0], sd_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        spi_rx_push = 1'b1;
                        got_byte_d  = 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q != 3'd0) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        sd_o_d     = tx_shift_q[6];
                    end else if (got_byte_q) begin
                        tx_shift_d = tx_next;
                        spi_tx_pop = ~tx_empty;
                        tx_unf_set = tx_empty;
                        sd_o_d     = tx_next[7];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign accept      = tl_i.a_valid & ~d_valid_q;
    assign is_get      = (tl_i.a_opcode == Get);
    assign is_put      = (tl_i.a_opcode == PutFullData) | (tl_i.a_opcode == PutPartialData);
    assign reg_idx     = tl_i.a_address[3:2];
    assign bus_err     = (tl_i.a_address[31:4] != 28'd0) | ~(is_get | is_put);
    assign bus_wr      = accept & is_put & ~bus_err;
    assign bus_rd      = accept & is_get & ~bus_err;
    assign bus_rx_pop  = bus_rd & (reg_idx == 2'd0) & ~rx_empty;
    assign bus_tx_push = bus_wr & (reg_idx == 2'd1);
    assign ctrl_wr     = bus_wr & (reg_idx == 2'd3);
    assign clr_sticky  = ctrl_wr & tl_i.a_data[8];
    assign rx_flush    = ctrl_wr & tl_i.a_data[9];
    assign tx_flush    = ctrl_wr & tl_i.a_data[10];

    assign status = {16'd0, sat4(tx_level), sat4(rx_level), (state_q == StActive),
                     tx_ovf_q, tx_unf_q, rx_ovf_q, tx_full, tx_empty, rx_full, rx_empty};

    always_comb begin
        rdata = 32'd0;
        case (reg_idx)
            2'd0:    rdata = rx_empty ? 32'd0 : {24'd0, rx_head};
            2'd2:    rdata = status;
            2'd3:    rdata = {30'd0, tx_ie_q, rx_ie_q};
            default: rdata = 32'd0;
        endcase
    end

    always_comb begin
        rx_ie_d    = ctrl_wr ? tl_i.a_data[0] : rx_ie_q;
        tx_ie_d    = ctrl_wr ? tl_i.a_data[1] : tx_ie_q;
        rx_ovf_d   = rx_drop    | (rx_ovf_q & ~clr_sticky);
        tx_unf_d   = tx_unf_set | (tx_unf_q & ~clr_sticky);
        tx_ovf_d   = tx_drop    | (tx_ovf_q & ~clr_sticky);
        d_valid_d  = accept | (d_valid_q & ~tl_i.d_ready);
        d_opcode_d = d_opcode_q;
        d_size_d   = d_size_q;
        d_source_d = d_source_q;
        d_data_d   = d_data_q;
        d_error_d  = d_error_q;
        if (accept) begin
            d_opcode_d = is_get ? AccessAckData : AccessAck;
            d_size_d   = tl_i.a_size;
            d_source_d = tl_i.a_source;
            d_data_d   = bus_rd ? rdata : 32'd0;
            d_error_d  = bus_err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            sclk_sync_q <= 3'b000;
            ss_sync_q   <= 3'b111;
            sd_sync_q   <= 2'b00;
            bit_cnt_q   <= 3'd0;
            got_byte_q  <= 1'b0;
            sd_o_q      <= 1'b1;
            sd_oe_q     <= 1'b0;
            rx_ie_q     <= 1'b0;
            tx_ie_q     <= 1'b0;
            rx_ovf_q    <= 1'b0;
            tx_unf_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            d_valid_q   <= 1'b0;
            d_opcode_q  <= 3'd0;
            d_size_q    <= 2'd0;
            d_source_q  <= 8'd0;
            d_data_q    <= 32'd0;
            d_error_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            sd_sync_q   <= sd_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            got_byte_q  <= got_byte_d;
            sd_o_q      <= sd_o_d;
            sd_oe_q     <= sd_oe_d;
            rx_ie_q     <= rx_ie_d;
            tx_ie_q     <= tx_ie_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_unf_q    <= tx_unf_d;
            tx_ovf_q    <= tx_ovf_d;
            d_valid_q   <= d_valid_d;
            d_opcode_q  <= d_opcode_d;
            d_size_q    <= d_size_d;
            d_source_q  <= d_source_d;
            d_data_q    <= d_data_d;
            d_error_q   <= d_error_d;
        end
    end

    always_ff @(posedge clk_i) begin
        tx_shift_q <= tx_shift_d;
        rx_shift_q <= rx_shift_d;
    end

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = d_valid_q;
        tl_o.d_opcode = d_opcode_q;
        tl_o.d_size   = d_size_q;
        tl_o.d_source = d_source_q;
        tl_o.d_data   = d_data_q;
        tl_o.d_error  = d_error_q;
        tl_o.a_ready  = ~d_valid_q;
    end

    assign sd_o      = sd_o_q;
    assign sd_oe_o   = sd_oe_q;
    assign intr_rx_o = rx_ie_q & ~rx_empty;
    assign intr_tx_o = tx_ie_q & tx_empty;
endmodule

// File: tb/tb_spi_device_lite.sv
// Bench for spi_device_lite: randomised SPI frames and bus traffic against a queue-based model.
module tb_spi_device_lite;
    import tlul_pkg::*;

    localparam int Depth = 8;
    localparam int H     = 8;   // half SPI period in clk cycles

    logic     clk = 1'b0;
    logic     rst_ni = 1'b0;
    tl_h2d_t  tl_i;
    tl_d2h_t  tl_o;
    logic     sclk = 1'b0, ss_n = 1'b1, sd_in = 1'b0;
    logic     sd_o, sd_oe, intr_rx, intr_tx;

    int checks = 0;
    int errors = 0;

    logic [7:0] q_rx[$];
    logic [7:0] q_tx[$];
    logic       m_rxo = 0, m_txu = 0, m_txo = 0, m_rxie = 0, m_txie = 0;
    logic [7:0] mo [16];
    logic [7:0] mi [16];
    logic [7:0] m_exp [17];

    always #5 clk = ~clk;

    spi_device_lite #(.FifoDepth(Depth), .IdleByte(8'hFF)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .tl_i(tl_i), .tl_o(tl_o),
        .sclk_i(sclk), .ss_ni(ss_n), .sd_i(sd_in),
        .sd_o(sd_o), .sd_oe_o(sd_oe), .intr_rx_o(intr_rx), .intr_tx_o(intr_tx)
    );

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'd0;
        s[0]     = (q_rx.size() == 0);
        s[1]     = (q_rx.size() == Depth);
        s[2]     = (q_tx.size() == 0);
        s[3]     = (q_tx.size() == Depth);
        s[4]     = m_rxo;
        s[5]     = m_txu;
        s[6]     = m_txo;
        s[11:8]  = 4'(q_rx.size());
        s[15:12] = 4'(q_tx.size());
        return s;
    endfunction

    function automatic logic [7:0] m_load();
        if (q_tx.size() == 0) begin
            m_txu = 1'b1;
            return 8'hFF;
        end
        return q_tx.pop_front();
    endfunction

    function automatic void m_push_tx(input logic [7:0] b);
        if (q_tx.size() < Depth) q_tx.push_back(b);
        else m_txo = 1'b1;
    endfunction

    // A frame of nbits: one TX byte at select, then one more after every completed byte
    // that is followed by further clocking (the last falling edge coincides with deselect).
    function automatic void m_frame(input int nbits);
        int nb;
        bit partial;
        nb = nbits / 8;
        partial = (nbits % 8) != 0;
        m_exp[0] = m_load();
        for (int j = 0; j < nb; j++) begin
            if (q_rx.size() < Depth) q_rx.push_back(mo[j]);
            else m_rxo = 1'b1;
            if (j < nb - 1 || partial) m_exp[j+1] = m_load();
        end
    endfunction

    function automatic void m_ctrl(input logic [31:0] d);
        m_rxie = d[0];
        m_txie = d[1];
        if (d[8])  begin m_rxo = 0; m_txu = 0; m_txo = 0; end
        if (d[9])  q_rx.delete();
        if (d[10]) q_tx.delete();
    endfunction

    // ---------------- drivers ----------------
    task automatic bus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        logic [7:0] src;
        int n;
        src = 8'($urandom_range(0, 255));
        @(negedge clk);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_address = addr;
        tl_i.a_data    = wdata;
        tl_i.a_size    = 2'd2;
        tl_i.a_source  = src;
        tl_i.a_mask    = 4'hF;
        tl_i.d_ready   = 1'b1;
        @(negedge clk);
        tl_i.a_valid = 1'b0;
        n = 0;
        while (!tl_o.d_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        rdata = tl_o.d_data;
        err   = tl_o.d_error;
        checks++;
        if (tl_o.d_valid !== 1'b1 || tl_o.d_source !== src) begin
            errors++;
            $display("FAIL bus_response: got d_valid %b source %h, expected d_valid 1 source %h",
                     tl_o.d_valid, tl_o.d_source, src);
            err = 1'bx;
        end
    endtask

    task automatic spi_frame(input int nbits);
        int bi, k;
        @(negedge clk);
        ss_n = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bi = i / 8;
            k  = 7 - (i % 8);
            sd_in = mo[bi][k];
            repeat (H) @(negedge clk);
            sclk = 1'b1;
            mi[bi][k] = sd_o;
            if (i == 0) begin
                checks++;
                if (sd_oe !== 1'b1) begin
                    errors++;
                    $display("FAIL sd_oe_active: got %b expected 1", sd_oe);
                end
            end
            repeat (H) @(negedge clk);
            sclk = 1'b0;
            if (i == nbits - 1 && nbits % 8 == 0) ss_n = 1'b1;
        end
        if (nbits % 8 != 0) begin
            repeat (H) @(negedge clk);
            ss_n = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (sd_oe !== 1'b0 || sd_o !== 1'b1) begin
                errors++;
                $display("FAIL abort_release: got oe %b sd_o %b expected oe 0 sd_o 1", sd_oe, sd_o);
            end
        end
        repeat (2 * H) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        logic e;
        tl_i = '0;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sd_o !== 1'b1 || sd_oe !== 1'b0 || tl_o.a_ready !== 1'b1 || tl_o.d_valid !== 1'b0 ||
            intr_rx !== 1'b0 || intr_tx !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got sd_o %b oe %b a_ready %b d_valid %b irq %b%b expected 1 0 1 0 00",
                     sd_o, sd_oe, tl_o.a_ready, tl_o.d_valid, intr_rx, intr_tx);
        end
        rst_ni = 1'b1;
        bus(Get, 32'h8, 0, d, e);
        checks++;
        if (d !== m_status() || e !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got %h err %b expected %h err 0", d, e, m_status());
        end
        bus(Get, 32'hC, 0, d, e);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %h expected 0", d);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d, exp;
        logic e;
        bus(PutFullData, 32'h4, 32'hA5, d, e); m_push_tx(8'hA5);
        bus(PutFullData, 32'h4, 32'h3C, d, e); m_push_tx(8'h3C);
        mo[0] = 8'h12; mo[1] = 8'h34;
        m_frame(16);
        spi_frame(16);
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (mi[j] !== m_exp[j]) begin
                errors++;
                $display("FAIL basic_miso%0d: got %h expected %h", j, mi[j], m_exp[j]);
            end
        end
        for (int j = 0; j < 2; j++) begin
            bus(Get, 32'h0, 0, d, e);
            exp = {24'd0, q_rx.pop_front()};
            checks++;
            if (d !== exp || e !== 1'b0) begin
                errors++;
                $display("FAIL basic_rxdata%0d: got %h expected %h", j, d, exp);
            end
        end
        bus(Get, 32'h8, 0, d, e);
        checks++;
        if (d !== m_status()) begin
            errors++;
            $display("FAIL basic_status: got %h expected %h", d, m_status());
        end
    endtask

    task automatic test_underflow();
        logic [31:0] d, exp;
        logic e;
        mo[0] = 8'($urandom);
        m_frame(8);
        spi_frame(8);
        checks++;
        if (mi[0] !== m_exp[0]) begin
            errors++;
            $display("FAIL underflow_miso: got %h expected %h", mi[0], m_exp[0]);
        end
        bus(Get, 32'h8, 0, d, e);
        checks++;
        if (d !== m_status()) begin
            errors++;
            $display("FAIL underflow_status: got %h expected %h", d, m_status());
        end
        bus(PutFullData, 32'hC, 32'h100, d, e); m_ctrl(32'h100);
        bus(Get, 32'h8, 0, d, e);
        checks++;
        if (d !== m_status()) begin
            errors++;
            $display("FAIL underflow_cleared: got %h expected %h", d, m_status());
        end
        bus(Get, 32'h0, 0, d, e);
        exp = {24'd0, q_rx.pop_front()};
        checks++;
        if (d !== exp) begin
            errors++;
            $display("FAIL underflow_rxdata: got %h expected %h", d, exp);
        end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] d, exp;
        logic e;
        for (int j = 0; j < 9; j++) mo[j] = 8'($urandom);
        m_frame(72);
        spi_frame(72);
        bus(Get, 32'h8, 0, d, e);
        checks++;
        if (d !== m_status()) begin
            errors++;
            $display("FAIL overflow_status: got %h expected %h", d, m_status());
        end
        for (int j = 0; j < 9; j++) begin
            bus(Get, 32'h0, 0, d, e);
            exp = (q_rx.size() > 0) ? {24'd0, q_rx.pop_front()} : 32'd0;
            checks++;
            if (d !== exp || e !== 1'b0) begin
                errors++;
                $display("FAIL overflow_rxdata%0d: got %h err %b expected %h err 0", j, d, e, exp);
            end
        end
        bus(PutFullData, 32'hC, 32'h100, d, e); m_ctrl(32'h100);
    endtask

    task automatic test_abort();
        logic [31:0] d, exp;
        logic e;
        bus(PutFullData, 32'h4, {24'd0, 8'($urandom)}, d, e); m_push_tx(tl_i.a_data[7:0]);
        mo[0] = 8'($urandom);
        m_frame(5);
        spi_frame(5);
        bus(Get, 32'h8, 0, d, e);
        checks++;
        if (d !== m_status()) begin
            errors++;
            $display("FAIL abort_status: got %h expected %h", d, m_status());
        end
        bus(PutFullData, 32'h4, 32'h5A, d, e); m_push_tx(8'h5A);
        mo[0] = 8'($urandom);
        m_frame(8);
        spi_frame(8);
        checks++;
        if (mi[0] !== m_exp[0]) begin
            errors++;
            $display("FAIL abort_next_miso: got %h expected %h", mi[0], m_exp[0]);
        end
        bus(Get, 32'h0, 0, d, e);
        exp = (q_rx.size() > 0) ? {24'd0, q_rx.pop_front()} : 32'd0;
        checks++;
        if (d !== exp) begin
            errors++;
            $display("FAIL abort_next_rxdata: got %h expected %h", d, exp);
        end
        bus(PutFullData, 32'hC, 32'h100, d, e); m_ctrl(32'h100);
    endtask

    task automatic test_intr();
        logic [31:0] d;
        logic e;
        bus(PutFullData, 32'hC, 32'h1, d, e); m_ctrl(32'h1);
        mo[0] = 8'($urandom);
        m_frame(8);
        spi_frame(8);
        checks++;
        if (intr_rx !== (m_rxie && q_rx.size() > 0)) begin
            errors++;
            $display("FAIL intr_rx_set: got %b expected %b", intr_rx, m_rxie && q_rx.size() > 0);
        end
        bus(Get, 32'h0, 0, d, e); void'(q_rx.pop_front());
        @(negedge clk);
        checks++;
        if (intr_rx !== (m_rxie && q_rx.size() > 0)) begin
            errors++;
            $display("FAIL intr_rx_clear: got %b expected %b", intr_rx, m_rxie && q_rx.size() > 0);
        end
        bus(PutFullData, 32'hC, 32'h2, d, e); m_ctrl(32'h2);
        @(negedge clk);
        checks++;
        if (intr_tx !== (m_txie && q_tx.size() == 0)) begin
            errors++;
            $display("FAIL intr_tx_set: got %b expected %b", intr_tx, m_txie && q_tx.size() == 0);
        end
        bus(PutFullData, 32'h4, 32'h77, d, e); m_push_tx(8'h77);
        @(negedge clk);
        checks++;
        if (intr_tx !== (m_txie && q_tx.size() == 0)) begin
            errors++;
            $display("FAIL intr_tx_clear: got %b expected %b", intr_tx, m_txie && q_tx.size() == 0);
        end
        bus(PutFullData, 32'hC, 32'h500, d, e); m_ctrl(32'h500);
    endtask

    task automatic test_random();
        logic [31:0] d, exp;
        logic e;
        int npre, nb;
        for (int it = 0; it < 6; it++) begin
            npre = $urandom_range(0, 3);
            for (int j = 0; j < npre; j++) begin
                exp = {24'd0, 8'($urandom)};
                bus(PutFullData, 32'h4, exp, d, e); m_push_tx(exp[7:0]);
            end
            nb = $urandom_range(1, 3);
            for (int j = 0; j < nb; j++) mo[j] = 8'($urandom);
            m_frame(nb * 8);
            spi_frame(nb * 8);
            for (int j = 0; j < nb; j++) begin
                checks++;
                if (mi[j] !== m_exp[j]) begin
                    errors++;
                    $display("FAIL rand%0d_miso%0d: got %h expected %h", it, j, mi[j], m_exp[j]);
                end
            end
            bus(Get, 32'h8, 0, d, e);
            checks++;
            if (d !== m_status()) begin
                errors++;
                $display("FAIL rand%0d_status: got %h expected %h", it, d, m_status());
            end
            for (int j = 0; j < nb; j++) begin
                bus(Get, 32'h0, 0, d, e);
                exp = (q_rx.size() > 0) ? {24'd0, q_rx.pop_front()} : 32'd0;
                checks++;
                if (d !== exp) begin
                    errors++;
                    $display("FAIL rand%0d_rxdata%0d: got %h expected %h", it, j, d, exp);
                end
            end
            if (it % 2 == 1) begin
                bus(PutFullData, 32'hC, 32'h500, d, e); m_ctrl(32'h500);
            end
        end
        bus(PutFullData, 32'hC, 32'h500, d, e); m_ctrl(32'h500);
    endtask

    task automatic test_bus_err();
        logic [31:0] d;
        logic e;
        bus(Get, 32'h20, 0, d, e);
        checks++;
        if (d !== 32'd0 || e !== 1'b1) begin
            errors++;
            $display("FAIL err_get_unmapped: got data %h err %b expected data 0 err 1", d, e);
        end
        bus(PutFullData, 32'h20, 32'h3, d, e);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL err_put_unmapped: got err %b expected 1", e);
        end
        bus(3'h2, 32'hC, 32'h3, d, e);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL err_bad_opcode: got err %b expected 1", e);
        end
        bus(Get, 32'hC, 0, d, e);
        checks++;
        if (d !== {30'd0, m_txie, m_rxie}) begin
            errors++;
            $display("FAIL err_no_side_effect: got ctrl %h expected %h", d, {30'd0, m_txie, m_rxie});
        end
        @(negedge clk);
        tl_i.a_valid = 1'b1; tl_i.a_opcode = Get; tl_i.a_address = 32'h20; tl_i.d_ready = 1'b0;
        @(negedge clk);
        tl_i.a_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (tl_o.a_ready !== 1'b0 || tl_o.d_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_cycle%0d: got a_ready %b d_valid %b expected 0 1",
                         c, tl_o.a_ready, tl_o.d_valid);
            end
            @(negedge clk);
        end
        tl_i.d_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (tl_o.d_valid !== 1'b0 || tl_o.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got d_valid %b a_ready %b expected 0 1", tl_o.d_valid, tl_o.a_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic e;
        bus(PutFullData, 32'hC, 32'h3, d, e); m_ctrl(32'h3);
        bus(PutFullData, 32'h4, 32'h00, d, e); m_push_tx(8'h00);
        @(negedge clk);
        ss_n = 1'b0; sd_in = 1'b1;
        repeat (H) @(negedge clk);
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (sd_oe !== 1'b1 || sd_o !== 1'b0 || intr_tx !== 1'b1) begin
            errors++;
            $display("FAIL midframe_pre: got oe %b sd_o %b irq_tx %b expected 1 0 1", sd_oe, sd_o, intr_tx);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (sd_o !== 1'b1 || sd_oe !== 1'b0 || tl_o.a_ready !== 1'b1 || tl_o.d_valid !== 1'b0 ||
            intr_rx !== 1'b0 || intr_tx !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: got sd_o %b oe %b a_ready %b d_valid %b irq %b%b expected 1 0 1 0 00",
                     sd_o, sd_oe, tl_o.a_ready, tl_o.d_valid, intr_rx, intr_tx);
        end
        sclk = 1'b0; ss_n = 1'b1;
        q_rx.delete(); q_tx.delete();
        m_rxo = 0; m_txu = 0; m_txo = 0; m_rxie = 0; m_txie = 0;
        repeat (4) @(negedge clk);
        rst_ni = 1'b1;
        bus(Get, 32'h8, 0, d, e);
        checks++;
        if (d !== m_status()) begin
            errors++;
            $display("FAIL midframe_status: got %h expected %h", d, m_status());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_rx_overflow();
        test_abort();
        test_intr();
        test_random();
        test_bus_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
